// File: rtl/clock_domain_import.sv
// Destination side of a four-phase CDC handshake: synchronises handshake_valid,
// captures the unsynchronised data word once per handshake into a 2-entry output FIFO.
module clock_domain_import #(
    parameter int SIZE = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] handshake_data,
    input  logic            handshake_valid,
    output logic            handshake_ack,
    output logic [SIZE-1:0] data,
    output logic            valid,
    input  logic            ready
);

    typedef enum logic {
        WAIT_VALID   = 1'b0,
        WAIT_RELEASE = 1'b1
    } state_t;

    state_t          state;
    logic            valid_x;
    logic            valid_sync;
    logic [1:0]      count;
    logic            rd_ptr;
    logic            wr_ptr;
    logic [SIZE-1:0] mem [2];

    logic full;
    logic push;
    logic pop;

    // Full is judged on the pre-edge count, so a pop never frees room on the same edge.
    assign full  = (count == 2'd2);
    assign valid = (count != 2'd0);
    assign data  = mem[rd_ptr];
    assign push  = (state == WAIT_VALID) && valid_sync && !full;
    assign pop   = valid && ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_x       <= 1'b0;
            valid_sync    <= 1'b0;
            handshake_ack <= 1'b0;
            state         <= WAIT_VALID;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
        end else begin
            valid_x    <= handshake_valid;
            valid_sync <= valid_x;

            case (state)
                WAIT_VALID: begin
                    if (push) begin
                        handshake_ack <= 1'b1;
                        state         <= WAIT_RELEASE;
                    end
                end
                WAIT_RELEASE: begin
                    if (!valid_sync) begin
                        handshake_ack <= 1'b0;
                        state         <= WAIT_VALID;
                    end
                end
                default: state <= WAIT_VALID;
            endcase

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: contents are only observed through a non-zero count.
    always_ff @(posedge clk) begin
        if (rst_n && push) mem[wr_ptr] <= handshake_data;
    end

    assert property (@(posedge clk) disable iff (!rst_n) count <= 2'd2);
    assert property (@(posedge clk) disable iff (!rst_n) $rose(handshake_ack) |-> $past(valid_sync));

endmodule

// File: tb/tb_clock_domain_import.sv
// Directed + randomized bench for clock_domain_import; the source side is driven
// asynchronously with random delays and a queue holds the words expected at the output.
module tb_clock_domain_import;
    localparam int SIZE = 7;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            hv = 1'b0;
    logic            ready = 1'b0;
    logic [SIZE-1:0] hd = '0;
    logic            ack;
    logic            valid;
    logic [SIZE-1:0] data;

    int              n_cmp = 0;
    int              n_bad = 0;
    int              n_sent = 0;
    int              n_got = 0;
    int              n_disc = 0;
    logic [SIZE-1:0] last_got = '0;
    logic [SIZE-1:0] exp_q [$];

    clock_domain_import #(.SIZE(SIZE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .handshake_data  (hd),
        .handshake_valid (hv),
        .handshake_ack   (ack),
        .data            (data),
        .valid           (valid),
        .ready           (ready)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consumer: a word is taken on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid === 1'b1 && ready === 1'b1) begin
            n_got++;
            last_got = data;
            check("model_has_word", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("pop_order", 32'(data), 32'(exp_q.pop_front()));
        end
    end

    // The acknowledge may only appear while the source is still presenting a word.
    always @(posedge ack) begin
        if (rst_n === 1'b1) check("ack_rise_with_valid", 32'(hv), 32'd1);
    end

    task automatic wait_ack(input logic lvl, input int max_ns, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_ns; i++) begin
            if (ack === lvl) begin
                ok = 1'b1;
                break;
            end
            #1;
        end
    endtask

    task automatic send(input logic [SIZE-1:0] w, input int dmax);
        bit ok;
        hd = w;
        #($urandom_range(1, dmax));
        hv = 1'b1;
        wait_ack(1'b1, 4000, ok);
        check("send_ack_high", 32'(ok), 32'd1);
        if (ok) begin
            exp_q.push_back(w);
            n_sent++;
        end
        #($urandom_range(1, dmax));
        hv = 1'b0;
        wait_ack(1'b0, 200, ok);
        check("send_ack_low", 32'(ok), 32'd1);
    endtask

    task automatic drain();
        @(posedge clk); #2;
        ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic random_phase(input int dmax, input int nwords);
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < nwords; i++) send(SIZE'($urandom_range(0, 127)), dmax);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #2;
                    ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
    endtask

    initial begin
        bit ok;
        int got0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        rst_n = 1'b1;
        ready = 1'b1;

        // Single transfer: output appears after the 3rd edge, same edge as ack
        @(negedge clk);
        hd = 7'h55;
        hv = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            if (e < 3) begin
                check("lat_valid_early", 32'(valid), 32'd0);
                check("lat_ack_early", 32'(ack), 32'd0);
            end
        end
        check("lat_valid", 32'(valid), 32'd1);
        check("lat_data", 32'(data), 32'h55);
        check("lat_ack", 32'(ack), 32'd1);
        exp_q.push_back(7'h55);
        n_sent++;
        @(negedge clk);
        hv = 1'b0;
        wait_ack(1'b0, 40, ok);
        check("single_ack_fall", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("single_pop_count", 32'(n_got), 32'd1);
        check("single_valid_low", 32'(valid), 32'd0);

        // Backpressure: two words buffer, the third is held off
        ready = 1'b0;
        send(7'h01, 10);
        send(7'h02, 10);
        @(negedge clk);
        hd = 7'h03;
        hv = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("bp_ack_held", 32'(ack), 32'd0);
        check("bp_valid", 32'(valid), 32'd1);
        check("bp_head", 32'(data), 32'h01);
        ready = 1'b1;
        wait_ack(1'b1, 200, ok);
        check("bp_release", 32'(ok), 32'd1);
        exp_q.push_back(7'h03);
        n_sent++;
        hv = 1'b0;
        wait_ack(1'b0, 200, ok);
        check("bp_ack_fall", 32'(ok), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        check("bp_total", 32'(n_got), 32'd4);
        check("bp_last", 32'(last_got), 32'h03);

        // Simultaneous push and pop with one word buffered
        ready = 1'b0;
        send(7'h11, 10);
        @(negedge clk);
        hd = 7'h22;
        hv = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
        exp_q.push_back(7'h22);
        n_sent++;
        check("pp_ack", 32'(ack), 32'd1);
        check("pp_valid", 32'(valid), 32'd1);
        check("pp_head", 32'(data), 32'h22);
        @(negedge clk);
        hv = 1'b0;
        wait_ack(1'b0, 40, ok);
        check("pp_ack_fall", 32'(ok), 32'd1);
        send(7'h33, 10);
        @(negedge clk);
        hd = 7'h44;
        hv = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("pp_full_block", 32'(ack), 32'd0);
        ready = 1'b1;
        wait_ack(1'b1, 200, ok);
        check("pp_release", 32'(ok), 32'd1);
        exp_q.push_back(7'h44);
        n_sent++;
        hv = 1'b0;
        wait_ack(1'b0, 200, ok);
        drain();
        check("pp_last", 32'(last_got), 32'h44);

        // Ten words through the wrapping pointers with a random consumer
        random_phase(12, 10);

        // Reset while full with ack high
        @(posedge clk); #1;
        ready = 1'b0;
        send(7'h0A, 10);
        @(negedge clk);
        hd = 7'h0B;
        hv = 1'b1;
        wait_ack(1'b1, 200, ok);
        check("rst_pre_ack", 32'(ok), 32'd1);
        exp_q.push_back(7'h0B);
        n_sent++;
        got0 = n_got;
        @(negedge clk);
        rst_n = 1'b0;
        hv = 1'b0;
        n_disc += exp_q.size();
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_stays_empty", 32'(valid), 32'd0);
        ready = 1'b1;
        send(7'h7F, 10);
        drain();
        check("rst_next_count", 32'(n_got - got0), 32'd1);
        check("rst_next_word", 32'(last_got), 32'h7F);

        // Random source timing: fast, slow and comparable to the destination clock
        random_phase(3, 20);
        random_phase(40, 20);
        random_phase(10, 20);

        check("final_count", 32'(n_got), 32'(n_sent - n_disc));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
